// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared widths and request bundle
// for the register-file writeback arbiter.
package regfile_wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 2 ** ADDR_W;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [NREG-1:0] onehot(
    input logic [ADDR_W-1:0] a
  );
    logic [NREG-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_arb.sv
// wb_rr_arb2: two-requester round-robin arbiter,
// prio flips only when a conflict is granted.
module wb_rr_arb2
  import regfile_wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_q;
  logic prio_d;
  logic en;
  logic both;

  assign en   = rst_n & ~flush;
  assign both = req[0] & req[1];

  // grant selection and pointer update
  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    unique case (1'b1)
      (!en): begin
        gnt = 2'b00;
      end
      (en && both): begin
        gnt    = prio_q ? 2'b10 : 2'b01;
        prio_d = ~prio_q;
      end
      (en && !both): begin
        gnt = req;
      end
      default: begin
        gnt = 2'b00;
      end
    endcase
  end

  // priority pointer; load source wins first conflict
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= 1'b1;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the regfile write port between ALU and load.
// Optional counters enabled by defining WB_CONFLICT_CNT_EN.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data,
`ifdef WB_CONFLICT_CNT_EN
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       stall_cnt0,
  output logic [31:0]       stall_cnt1,
`endif
  output logic              WE3,
  output logic [ADDR_W-1:0] AD3,
  output logic [DATA_W-1:0] WD3,
  output logic [NREG-1:0]   pend
);

  wb_req_t   r0;
  wb_req_t   r1;
  wb_req_t   sel;
  logic [1:0] gnt;

  logic              we_q;
  logic              we_d;
  logic [ADDR_W-1:0] ad_q;
  logic [ADDR_W-1:0] ad_d;
  logic [DATA_W-1:0] wd_q;
  logic [DATA_W-1:0] wd_d;
  logic [NREG-1:0]   pend_q;
  logic [NREG-1:0]   pend_d;

  assign r0 = '{valid: s0_valid, addr: s0_addr, data: s0_data};
  assign r1 = '{valid: s1_valid, addr: s1_addr, data: s1_data};

  wb_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .req   ({r1.valid, r0.valid}),
    .gnt   (gnt)
  );

  assign s0_ready = gnt[0];
  assign s1_ready = gnt[1];

  // pick the granted request, drop x0 writes
  always_comb begin
    sel    = gnt[1] ? r1 : r0;
    we_d   = 1'b0;
    ad_d   = ad_q;
    wd_d   = wd_q;
    pend_d = '0;
    if ((|gnt) && (sel.addr != '0)) begin
      we_d   = 1'b1;
      ad_d   = sel.addr;
      wd_d   = sel.data;
      pend_d = onehot(sel.addr);
    end
  end

  // single write-port output stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      ad_q   <= '0;
      wd_q   <= '0;
      pend_q <= '0;
    end else begin
      we_q   <= we_d;
      ad_q   <= ad_d;
      wd_q   <= wd_d;
      pend_q <= pend_d;
    end
  end

  assign WE3  = we_q;
  assign AD3  = ad_q;
  assign WD3  = wd_q;
  assign pend = pend_q;

`ifdef WB_CONFLICT_CNT_EN
  logic [31:0] conf_q;
  logic [31:0] conf_d;
  logic [31:0] st0_q;
  logic [31:0] st0_d;
  logic [31:0] st1_q;
  logic [31:0] st1_d;

  // saturating event counters
  always_comb begin
    conf_d = conf_q;
    st0_d  = st0_q;
    st1_d  = st1_q;
    if (s0_valid && s1_valid && !flush && conf_q != '1)
      conf_d = conf_q + 32'd1;
    if (s0_valid && !s0_ready && st0_q != '1)
      st0_d = st0_q + 32'd1;
    if (s1_valid && !s1_ready && st1_q != '1)
      st1_d = st1_q + 32'd1;
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conf_q <= '0;
      st0_q  <= '0;
      st1_q  <= '0;
    end else begin
      conf_q <= conf_d;
      st0_q  <= st0_d;
      st1_q  <= st1_d;
    end
  end

  assign conflict_cnt = conf_q;
  assign stall_cnt0   = st0_q;
  assign stall_cnt1   = st1_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of grant order,
// output stage, x0 drop, flush and reset.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        s0_valid;
  logic        s0_ready;
  logic [4:0]  s0_addr;
  logic [31:0] s0_data;
  logic        s1_valid;
  logic        s1_ready;
  logic [4:0]  s1_addr;
  logic [31:0] s1_data;
  logic        WE3;
  logic [4:0]  AD3;
  logic [31:0] WD3;
  logic [31:0] pend;
`ifdef WB_CONFLICT_CNT_EN
  logic [31:0] conflict_cnt;
  logic [31:0] stall_cnt0;
  logic [31:0] stall_cnt1;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] rf [32];

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .s0_valid     (s0_valid),
    .s0_ready     (s0_ready),
    .s0_addr      (s0_addr),
    .s0_data      (s0_data),
    .s1_valid     (s1_valid),
    .s1_ready     (s1_ready),
    .s1_addr      (s1_addr),
    .s1_data      (s1_data),
`ifdef WB_CONFLICT_CNT_EN
    .conflict_cnt (conflict_cnt),
    .stall_cnt0   (stall_cnt0),
    .stall_cnt1   (stall_cnt1),
`endif
    .WE3          (WE3),
    .AD3          (AD3),
    .WD3          (WD3),
    .pend         (pend)
  );

  // register-file model written by the port
  always @(posedge clk) begin
    if (WE3) rf[AD3] <= WD3;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    s0_valid = 1'b1;
    s0_addr  = 5'd3;
    s0_data  = 32'hA0A0_0003;
    s1_valid = 1'b1;
    s1_addr  = 5'd4;
    s1_data  = 32'hB0B0_0004;

    // reset with both valids high
    #1;
    chk("rst_rdy0", {31'd0, s0_ready}, 32'd0);
    chk("rst_rdy1", {31'd0, s1_ready}, 32'd0);
    tick();
    tick();
    chk("rst_we", {31'd0, WE3}, 32'd0);
    chk("rst_pend", pend, 32'd0);
    chk("rst_ad", {27'd0, AD3}, 32'd0);
    chk("rst_wd", WD3, 32'd0);
    chk("rst_rdy0b", {31'd0, s0_ready}, 32'd0);
    chk("rst_rdy1b", {31'd0, s1_ready}, 32'd0);

    // release: first conflict goes to s1
    rst_n = 1'b1;
    #1;
    chk("c0_rdy1", {31'd0, s1_ready}, 32'd1);
    chk("c0_rdy0", {31'd0, s0_ready}, 32'd0);
    tick();
    chk("c1_we", {31'd0, WE3}, 32'd1);
    chk("c1_ad", {27'd0, AD3}, 32'd4);
    chk("c1_wd", WD3, 32'hB0B0_0004);
    chk("c1_pend", pend, 32'h0000_0010);
    chk("c1_rdy0", {31'd0, s0_ready}, 32'd1);
    tick();
    chk("c2_we", {31'd0, WE3}, 32'd1);
    chk("c2_ad", {27'd0, AD3}, 32'd3);
    chk("c2_pend", pend, 32'h0000_0008);
    tick();
    chk("c3_we", {31'd0, WE3}, 32'd1);
    chk("c3_ad", {27'd0, AD3}, 32'd4);
    tick();
    chk("c4_we", {31'd0, WE3}, 32'd1);
    chk("c4_ad", {27'd0, AD3}, 32'd3);
    chk("c4_wd", WD3, 32'hA0A0_0003);
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    tick();
    chk("c5_we", {31'd0, WE3}, 32'd0);
    chk("c5_pend", pend, 32'd0);

    // single source write
    s0_valid = 1'b1;
    s0_addr  = 5'd5;
    s0_data  = 32'hDEAD_BEEF;
    #1;
    chk("s_rdy0", {31'd0, s0_ready}, 32'd1);
    chk("s_rdy1", {31'd0, s1_ready}, 32'd0);
    tick();
    s0_valid = 1'b0;
    chk("s_we", {31'd0, WE3}, 32'd1);
    chk("s_ad", {27'd0, AD3}, 32'd5);
    chk("s_wd", WD3, 32'hDEAD_BEEF);
    chk("s_pend", pend, 32'h0000_0020);
    tick();
    chk("s_we_off", {31'd0, WE3}, 32'd0);
    chk("s_pend_off", pend, 32'd0);
    chk("s_rf5", rf[5], 32'hDEAD_BEEF);

    // x0 write is accepted then dropped
    s1_valid = 1'b1;
    s1_addr  = 5'd0;
    s1_data  = 32'h1234_5678;
    #1;
    chk("x0_rdy1", {31'd0, s1_ready}, 32'd1);
    tick();
    s1_valid = 1'b0;
    chk("x0_we", {31'd0, WE3}, 32'd0);
    chk("x0_pend", pend, 32'd0);

    // flush blocks grants and keeps prio
    s0_valid = 1'b1;
    s0_addr  = 5'd9;
    s0_data  = 32'h0000_0099;
    s1_valid = 1'b1;
    s1_addr  = 5'd10;
    s1_data  = 32'h0000_00AA;
    flush    = 1'b1;
    #1;
    chk("f_rdy0", {31'd0, s0_ready}, 32'd0);
    chk("f_rdy1", {31'd0, s1_ready}, 32'd0);
    tick();
    chk("f_we", {31'd0, WE3}, 32'd0);
    chk("f_pend", pend, 32'd0);
    flush = 1'b0;
    #1;
    chk("f_rdy1_after", {31'd0, s1_ready}, 32'd1);
    tick();
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    chk("f_ad", {27'd0, AD3}, 32'd10);
    chk("f_pend2", pend, 32'h0000_0400);

    // same register, prio=0: s0 then s1, final 2
    s0_valid = 1'b1;
    s0_addr  = 5'd7;
    s0_data  = 32'd1;
    s1_valid = 1'b1;
    s1_addr  = 5'd7;
    s1_data  = 32'd2;
    #1;
    chk("sr0_rdy0", {31'd0, s0_ready}, 32'd1);
    tick();
    s0_valid = 1'b0;
    #1;
    chk("sr0_rdy1", {31'd0, s1_ready}, 32'd1);
    tick();
    s1_valid = 1'b0;
    tick();
    chk("sr0_rf7", rf[7], 32'd2);

    // same register, prio=1: s1 then s0, final 1
    s0_valid = 1'b1;
    s1_valid = 1'b1;
    #1;
    chk("sr1_rdy1", {31'd0, s1_ready}, 32'd1);
    tick();
    s1_valid = 1'b0;
    #1;
    chk("sr1_rdy0", {31'd0, s0_ready}, 32'd1);
    tick();
    s0_valid = 1'b0;
    tick();
    chk("sr1_rf7", rf[7], 32'd1);

    // reset drops an in-flight write and restores prio
    s1_valid = 1'b1;
    s1_addr  = 5'd12;
    s1_data  = 32'h0000_0C0C;
    tick();
    s1_valid = 1'b0;
    chk("mr_we", {31'd0, WE3}, 32'd1);
    s0_valid = 1'b1;
    s1_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("mr_rdy0", {31'd0, s0_ready}, 32'd0);
    chk("mr_rdy1", {31'd0, s1_ready}, 32'd0);
    tick();
    chk("mr_we_off", {31'd0, WE3}, 32'd0);
    chk("mr_pend", pend, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mr_prio", {31'd0, s1_ready}, 32'd1);
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
